// File: rtl/alarm_trigger_module_if.sv
// alarm_trigger_module_if: alarm-reader bus between time/alarm registers, control buttons and buzzer
//   inputs to reader : CTI, Q_r0..Q_r6, ON_OFF, MIN_TICK, SNOOZE, STOP
//   outputs of reader: ALARM, RINGING, SNOOZING, SNZ_CNT
interface alarm_trigger_module_if;
  logic [14:0] CTI;
  logic [12:0] Q_r0, Q_r1, Q_r2, Q_r3, Q_r4, Q_r5, Q_r6;
  logic ON_OFF, MIN_TICK, SNOOZE, STOP;
  logic ALARM, RINGING, SNOOZING;
  logic [1:0] SNZ_CNT;
  modport master (
    output CTI, Q_r0, Q_r1, Q_r2, Q_r3, Q_r4, Q_r5, Q_r6, ON_OFF, MIN_TICK, SNOOZE, STOP,
    input ALARM, RINGING, SNOOZING, SNZ_CNT
  );
  modport slave (
    input CTI, Q_r0, Q_r1, Q_r2, Q_r3, Q_r4, Q_r5, Q_r6, ON_OFF, MIN_TICK, SNOOZE, STOP,
    output ALARM, RINGING, SNOOZING, SNZ_CNT
  );
endinterface

// File: rtl/alarm_trigger_module.sv
// alarm_trigger_module: per-minute alarm match plus ring/snooze/stop state machine driving the buzzer
//   Clk   : system clock, rising edge
//   CLEAR : asynchronous active-high reset
//   bus   : slave side of alarm_trigger_module_if (time, alarm words, buttons in; buzzer and status out)
module alarm_trigger_module #(
  parameter int RING_MIN = 5,
  parameter int SNOOZE_MIN = 9,
  parameter int MAX_SNOOZE = 3,
  parameter int BEEP_DIV = 4
) (
  input logic Clk,
  input logic CLEAR,
  alarm_trigger_module_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  state_t state, nxt;
  logic hit_q, hit_d;
  logic [3:0] ring_cnt, ring_n, snz_min, snzmin_n;
  logic [1:0] snz_cnt, snzcnt_n;
  logic [7:0] beep_cnt, beep_n;
  logic phase, phase_n, beep_wrap;
  logic [2:0] day;
  logic [12:0] sel;
  assign day = bus.CTI[14:12];
  // day 7 selects an all-zero word whose enable bit is clear, so it can never match
  assign sel = day == 3'd0 ? bus.Q_r0 : day == 3'd1 ? bus.Q_r1 : day == 3'd2 ? bus.Q_r2 :
               day == 3'd3 ? bus.Q_r3 : day == 3'd4 ? bus.Q_r4 : day == 3'd5 ? bus.Q_r5 :
               day == 3'd6 ? bus.Q_r6 : 13'd0;
  assign hit_d = bus.MIN_TICK & bus.ON_OFF & sel[12] & (sel[11:0] == bus.CTI[11:0]);
  assign beep_wrap = beep_cnt == 8'(BEEP_DIV - 1);
  always_ff @(posedge Clk or posedge CLEAR)
    if (CLEAR) begin
      state <= IDLE;
      hit_q <= 1'b0;
      ring_cnt <= '0;
      snz_min <= '0;
      snz_cnt <= '0;
      beep_cnt <= '0;
      phase <= 1'b0;
    end else begin
      state <= nxt;
      hit_q <= hit_d;
      ring_cnt <= ring_n;
      snz_min <= snzmin_n;
      snz_cnt <= snzcnt_n;
      beep_cnt <= beep_n;
      phase <= phase_n;
    end
  always_comb begin
    nxt = state;
    ring_n = ring_cnt;
    snzmin_n = snz_min;
    snzcnt_n = snz_cnt;
    beep_n = state == RING ? (beep_wrap ? 8'd0 : beep_cnt + 8'd1) : beep_cnt;
    phase_n = state == RING && beep_wrap ? ~phase : phase;
    if (!bus.ON_OFF) nxt = IDLE;
    else if (state == IDLE) begin
      if (hit_q) begin
        nxt = RING;
        beep_n = 8'd0;
        phase_n = 1'b1;
      end
    end else if (state == RING) begin
      if (bus.STOP) nxt = IDLE;
      else if (bus.SNOOZE && snz_cnt < 2'(MAX_SNOOZE)) begin
        nxt = SNOOZE;
        snzcnt_n = snz_cnt + 2'd1;
        snzmin_n = 4'd0;
      end else if (bus.MIN_TICK) begin
        ring_n = ring_cnt + 4'd1;
        if (ring_n == 4'(RING_MIN)) nxt = IDLE;
      end
    end else begin
      if (bus.STOP) nxt = IDLE;
      else if (bus.MIN_TICK) begin
        snzmin_n = snz_min + 4'd1;
        if (snzmin_n == 4'(SNOOZE_MIN)) begin
          nxt = RING;
          ring_n = 4'd0;
          beep_n = 8'd0;
          phase_n = 1'b1;
        end
      end
    end
    // every path into IDLE leaves the event counters clean for the next alarm
    if (nxt == IDLE) begin
      ring_n = 4'd0;
      snzmin_n = 4'd0;
      snzcnt_n = 2'd0;
      beep_n = 8'd0;
    end
  end
  assign bus.RINGING = state == RING;
  assign bus.SNOOZING = state == SNOOZE;
  assign bus.ALARM = state == RING && phase;
  assign bus.SNZ_CNT = snz_cnt;
endmodule
